warp_imem: RTL
==============

Name: warp_imem

Overview:
- Instruction-memory responder for the hart's fetch port; the memory side of the imem request/valid protocol.
- Accepts a fetch request (ren + 39-bit address) and returns one 64-bit fetch packet (two 32-bit instructions) after a fixed, parameterized latency.
- Flags out-of-window and misaligned requests with a fault.
- Exposes a side write port so a loader or bench can fill the program before or while the hart runs.

Parameters:
- BASE_ADDR, 39'h4000000000, byte address of word 0; matches the hart reset vector.
- DEPTH, 1024, number of 64-bit words (power of two, >= 2).
- LATENCY, 1, cycles from request accept to valid (legal range 1..8).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_imem_ren  in  1  fetch request strobe
- i_imem_raddr  in  39  fetch byte address
- o_imem_valid  out  1  one-cycle response strobe
- o_imem_rdata  out  64  [31:0] = instr at the word-aligned address; [63:32] = next instr
- o_imem_fault  out  1  qualifies valid; response carries no data
- o_imem_busy  out  1  a request is in flight and a new ren would be ignored
- i_wr_en  in  1  loader write enable
- i_wr_addr  in  $clog2(DEPTH)  loader word index
- i_wr_data  in  64  loader write data
- i_wr_strb  in  8  per-byte write enables

Behaviour:
- One clock (i_clk); reset is synchronous, active-high (i_rst).
- Reset values: o_imem_valid=0, o_imem_fault=0, o_imem_rdata=0, o_imem_busy=0, FSM=IDLE, latency counter=0. Array contents are not reset.
- Reset mid-operation: any pending request is discarded and no valid is produced. A ren in the reset cycle is ignored.
- FSM states IDLE, WAIT, RESP.
- Accept rule: ren is accepted in IDLE or RESP. In RESP this gives back-to-back fetches.
  - ren while in WAIT is ignored. o_imem_busy = (state==WAIT).
- Accept at cycle t → o_imem_valid=1 exactly at cycle t+LATENCY, for one cycle.
- Transitions on accept:
  - LATENCY==1: go to RESP.
  - LATENCY>1: go to WAIT, counter loaded with LATENCY-2; WAIT→RESP when counter==0, else decrement.
- RESP without ren → IDLE.
- Request decode, captured at accept:
  - off = raddr - BASE_ADDR (39-bit, unsigned).
  - in-range iff raddr >= BASE_ADDR and off < DEPTH*8.
  - word index = off[3+:log2(DEPTH)]. raddr[2] is ignored; the hart selects the half.
  - fault iff !in-range or raddr[1:0]!=0.
- Fault response: valid=1, fault=1, rdata=0, and the array is not read.
- Good response: fault=0, rdata = array[index].
- Outside the valid cycle: rdata holds 0, fault holds 0.
- Array read timing: a synchronous read is issued in the cycle before valid (t+LATENCY-1).
  - For LATENCY==1 this is the accept cycle, using raddr directly.
- Loader write:
  - bytes with i_wr_strb[k]=1 updated at the clock edge.
  - Write to the same index in the read-issue cycle → response returns OLD data.
  - Write in any earlier cycle → NEW data.
- Wrap-around: raddr below BASE_ADDR underflows off to a huge value → fault. The last word index (DEPTH-1) is valid; DEPTH*8 is a fault.

Decomposition:
- warp_pkg holds:
  - IMEM_AW=39 and IMEM_DW=64;
  - the warp_imem_state_t enum (IDLE, WAIT, RESP);
  - the default BASE_ADDR constant shared with the hart's RESET_ADDR.
- One sub-module, warp_imem_array: DEPTH x 64 synchronous-read RAM with one read port and one byte-strobed write port; old-data-on-collision semantics.

Test Plan:
- LATENCY=1, preload word0=64'h00100133_001000b3; ren@0x4000000000 in cycle t → valid=1, fault=0, rdata=64'h00100133001000b3 at t+1; valid=0 at t+2.
- LATENCY=3, ren held high for 4 cycles from t → accepts at t and t+3 only, busy=1 at t+1..t+2, valids at t+3 and t+6.
- LATENCY=1, back-to-back ren to 0x4000000000 then 0x4000000008 → consecutive valids with word0 then word1.
- ren@0x3FFFFFFFF8, ren@BASE+DEPTH*8, ren@0x4000000002 → each gives valid=1, fault=1, rdata=0; ren@BASE+DEPTH*8-4 → fault=0, returns word DEPTH-1.
- LATENCY=2, write word5=all ones with strb=8'h0F in the read-issue cycle of a fetch to word5 (prior 0) → rdata=0; refetch → 64'h00000000FFFFFFFF.
- LATENCY=4, assert i_rst 2 cycles after accept → no valid ever; all outputs 0 the cycle after reset; a new ren after reset is serviced normally.

Source files
------------

// File: rtl/warp_pkg.sv
// Shared fetch-port widths, the imem responder state type and the hart reset vector.
package warp_pkg;

   localparam int unsigned IMEM_AW = 39;
   localparam int unsigned IMEM_DW = 64;

   localparam logic [IMEM_AW-1:0] RESET_ADDR = 39'h40_0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } warp_imem_state_t;

endpackage

// File: rtl/warp_imem_array.sv
// DEPTH x 64 synchronous-read RAM, one read port and one byte-strobed write port.
// A same-edge write to the read index returns the previous contents.
module warp_imem_array
   import warp_pkg::*;
#(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     i_clk,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [IMEM_DW-1:0]       o_rd_data,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [IMEM_DW-1:0]       i_wr_data,
   input  logic [IMEM_DW/8-1:0]     i_wr_strb
);

   logic [IMEM_DW-1:0] mem_q [DEPTH];
   logic [IMEM_DW-1:0] rd_data_q;

   always_ff @(posedge i_clk) begin
      if (i_rd_en) begin
         rd_data_q <= mem_q[i_rd_addr];
      end
      if (i_wr_en) begin
         for (int unsigned k = 0; k < IMEM_DW/8; k++) begin
            if (i_wr_strb[k]) begin
               mem_q[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
            end
         end
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/warp_imem.sv
// Instruction-memory responder: fixed-latency fetch of a 64-bit packet with
// window/alignment fault reporting and a side loader write port.
module warp_imem
   import warp_pkg::*;
#(
   parameter logic [IMEM_AW-1:0] BASE_ADDR = RESET_ADDR,
   parameter int unsigned        DEPTH     = 1024,
   parameter int unsigned        LATENCY   = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_imem_ren,
   input  logic [IMEM_AW-1:0]       i_imem_raddr,
   output logic                     o_imem_valid,
   output logic [IMEM_DW-1:0]       o_imem_rdata,
   output logic                     o_imem_fault,
   output logic                     o_imem_busy,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [IMEM_DW-1:0]       i_wr_data,
   input  logic [IMEM_DW/8-1:0]     i_wr_strb
);

   localparam int unsigned        IDX_W     = $clog2(DEPTH);
   localparam logic [IMEM_AW-1:0] WIN_BYTES = IMEM_AW'(DEPTH) << 3;
   localparam logic [2:0]         CNT_INIT  = (LATENCY > 1) ? 3'(LATENCY - 2) : '0;

   warp_imem_state_t state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             fault_q;
   logic [IDX_W-1:0] idx_q;

   logic [IMEM_AW-1:0] off;
   logic               in_range;
   logic               req_fault;
   logic [IDX_W-1:0]   req_idx;
   logic               accept;
   logic               rd_en;
   logic [IDX_W-1:0]   rd_addr;
   logic [IMEM_DW-1:0] ram_data;

   // Addresses below BASE_ADDR wrap to a huge offset and fall out of the window.
   always_comb begin
      off       = i_imem_raddr - BASE_ADDR;
      in_range  = (i_imem_raddr >= BASE_ADDR) && (off < WIN_BYTES);
      req_fault = !in_range || (i_imem_raddr[1:0] != 2'b00);
      req_idx   = off[3 +: IDX_W];
      accept    = i_imem_ren && (state_q != WAIT);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            fault_q <= req_fault;
            idx_q   <= req_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 3'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // The read is issued in the cycle before valid; with LATENCY==1 that is the accept cycle.
   always_comb begin
      rd_addr = accept ? req_idx : idx_q;
      rd_en   = !i_rst && (state_d == RESP) && !(accept ? req_fault : fault_q);
   end

   warp_imem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .i_clk     (i_clk),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (ram_data),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_wr_strb (i_wr_strb)
   );

   always_comb begin
      o_imem_valid = (state_q == RESP);
      o_imem_busy  = (state_q == WAIT);
      o_imem_fault = o_imem_valid && fault_q;
      o_imem_rdata = (o_imem_valid && !fault_q) ? ram_data : '0;
   end

endmodule
